// File: rtl/cube_sequencer.sv
// cube_sequencer
//   Runs a queue of cube moves against an external cube core. A run loads the
//   initial cube state into the core, then issues queued moves one at a time,
//   waiting for each to complete, until the queue drains, the core reports the
//   cube solved, an illegal move is found, or the core times out.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   start, init_state           run request (IDLE/ERR only) and initial cube state
//   mv_wr, mv_data              move-queue push (codes 0-11 legal)
//   mv_full, mv_empty           move-queue flags
//   cb_store, cb_store_data     one-cycle state-load pulse and data to the core
//   cb_load, cb_d               one-cycle move-issue pulse and move code
//   cb_valid, cb_fin, cb_q      core move-complete, cube-solved, resulting state
//   busy, done, solved, error   run status
//   overflow                    sticky dropped-push flag, cleared by start
//   move_cnt, final_state       completed moves (saturating) and last cube state
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// STORE  | cb_store pulse with the registered initial state
// SETTLE | one quiet cycle after the store
// ISSUE  | inspect queue head: done / illegal move / issue move
// WAIT   | cb_load pulse on entry, then wait for cb_valid or timeout
// DONE   | one-cycle done pulse, results held
// ERR    | error held; needs start low for a cycle before start restarts
module cube_sequencer #(
  parameter int DEPTH = 16,
  parameter int TMO   = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [119:0] init_state,
  input  logic         mv_wr,
  input  logic [3:0]   mv_data,
  output logic         mv_full,
  output logic         mv_empty,
  output logic         cb_store,
  output logic [119:0] cb_store_data,
  output logic         cb_load,
  output logic [3:0]   cb_d,
  input  logic         cb_valid,
  input  logic         cb_fin,
  input  logic [119:0] cb_q,
  output logic         busy,
  output logic         done,
  output logic         solved,
  output logic         error,
  output logic         overflow,
  output logic [7:0]   move_cnt,
  output logic [119:0] final_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STORE, S_SETTLE, S_ISSUE, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t         r_state;
  logic [3:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overflow;
  logic           r_err_armed;
  logic [TW-1:0]  r_tmr;
  logic           r_cb_store;
  logic           r_cb_load;
  logic [3:0]     r_cb_d;
  logic [119:0]   r_store_data;
  logic [119:0]   r_final;
  logic [7:0]     r_move_cnt;
  logic           r_done;
  logic           r_solved;
  logic           r_error;

  logic           w_empty;
  logic           w_full;
  logic [3:0]     w_head;
  logic           w_pop;
  logic           w_flush;
  logic           w_push;
  logic           w_start_ok;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_head  = r_mem[r_rd_ptr];
  assign w_pop   = (r_state == S_ISSUE) && !w_empty;
  assign w_flush = (r_state == S_WAIT) && cb_valid && cb_fin;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  // A flush wins over any concurrent push so the queue is empty afterwards.
  assign w_push  = mv_wr && (!w_full || w_pop) && !w_flush;
  assign w_start_ok = start &&
                      ((r_state == S_IDLE) || ((r_state == S_ERR) && r_err_armed));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mv_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // A dropped push in the same cycle as start still reports overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (mv_wr && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_start_ok) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_err_armed  <= 1'b0;
      r_tmr        <= '0;
      r_cb_store   <= 1'b0;
      r_cb_load    <= 1'b0;
      r_cb_d       <= '0;
      r_store_data <= '0;
      r_final      <= '0;
      r_move_cnt   <= '0;
      r_done       <= 1'b0;
      r_solved     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_cb_store <= 1'b0;
      r_cb_load  <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if ((r_state == S_ERR) && !start) r_err_armed <= 1'b1;
          if (w_start_ok) begin
            r_store_data <= init_state;
            r_move_cnt   <= '0;
            r_solved     <= 1'b0;
            r_error      <= 1'b0;
            r_cb_store   <= 1'b1;
            r_state      <= S_STORE;
          end
        end
        S_STORE:  r_state <= S_SETTLE;
        S_SETTLE: r_state <= S_ISSUE;
        S_ISSUE: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_head >= 4'd12) begin
            r_error     <= 1'b1;
            r_err_armed <= 1'b0;
            r_state     <= S_ERR;
          end else begin
            r_cb_d    <= w_head;
            r_cb_load <= 1'b1;
            r_tmr     <= TW'(TMO);
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cb_valid) begin
            r_final <= cb_q;
            if (r_move_cnt != 8'hFF) r_move_cnt <= r_move_cnt + 8'd1;
            if (cb_fin) begin
              r_solved <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (r_tmr <= TW'(1)) begin
            // Terminal count: this was the TMO-th WAIT cycle without cb_valid.
            r_error     <= 1'b1;
            r_err_armed <= 1'b0;
            r_state     <= S_ERR;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mv_full       = w_full;
  assign mv_empty      = w_empty;
  assign overflow      = r_overflow;
  assign cb_store      = r_cb_store;
  assign cb_store_data = r_store_data;
  assign cb_load       = r_cb_load;
  assign cb_d          = r_cb_d;
  assign busy          = (r_state == S_STORE) || (r_state == S_SETTLE) ||
                         (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign done          = r_done;
  assign solved        = r_solved;
  assign error         = r_error;
  assign move_cnt      = r_move_cnt;
  assign final_state   = r_final;

endmodule

// File: tb/tb_cube_sequencer.sv
// Bench for cube_sequencer: table of complete runs plus hand-written
// sequences for timeout, error restart, overflow and mid-run reset.
module tb_cube_sequencer;

  localparam int DEPTH_T = 16;
  localparam int TMO_T   = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [119:0] init_state = '0;
  logic         mv_wr = 1'b0;
  logic [3:0]   mv_data = '0;
  logic         mv_full, mv_empty, cb_store, cb_load;
  logic [119:0] cb_store_data;
  logic [3:0]   cb_d;
  logic         cb_valid = 1'b0;
  logic         cb_fin = 1'b0;
  logic [119:0] cb_q = '0;
  logic         busy, done, solved, error, overflow;
  logic [7:0]   move_cnt;
  logic [119:0] final_state;

  cube_sequencer #(.DEPTH(DEPTH_T), .TMO(TMO_T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_state(init_state),
    .mv_wr(mv_wr), .mv_data(mv_data), .mv_full(mv_full), .mv_empty(mv_empty),
    .cb_store(cb_store), .cb_store_data(cb_store_data), .cb_load(cb_load),
    .cb_d(cb_d), .cb_valid(cb_valid), .cb_fin(cb_fin), .cb_q(cb_q),
    .busy(busy), .done(done), .solved(solved), .error(error),
    .overflow(overflow), .move_cnt(move_cnt), .final_state(final_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cube core model: cb_valid two cycles after the cb_load cycle, cb_q is the
  // move code replicated, cb_fin on the load numbered fin_abs.
  int         loads = 0, stores = 0, dones = 0, viol = 0, pend = 0;
  int         fin_abs = 0;
  bit         cube_dead = 1'b0;
  bit         prev_pulse = 1'b0;
  logic [3:0] cur_code = '0;
  logic [3:0] ld_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0;
      prev_pulse = 1'b0;
      cb_valid <= 1'b0;
      cb_fin   <= 1'b0;
    end else begin
      cb_valid <= 1'b0;
      cb_fin   <= 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cb_valid <= 1'b1;
          cb_fin   <= (fin_abs != 0) && (loads == fin_abs);
          cb_q     <= {30{cur_code}};
        end
      end
      if (cb_load) begin
        loads++;
        ld_q.push_back(cb_d);
        cur_code = cb_d;
        if (!cube_dead) pend = 1;
      end
      if (cb_store) stores++;
      if (done) dones++;
      if (cb_load && cb_store) viol++;
      if ((cb_load || cb_store) && prev_pulse) viol++;
      prev_pulse = cb_load || cb_store;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_moves(input int n, input logic [63:0] codes);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mv_wr = 1'b1;
      mv_data = codes[4*i +: 4];
    end
    @(negedge clk);
    mv_wr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s timeout waiting for done/error", name);
    end
  endtask

  typedef struct {
    int          n;
    logic [63:0] codes;     // first pushed move in the low nibble
    int          fin_at;    // 1-based move on which the core reports solved
    int          exp_cnt;
    bit          exp_solved;
    bit          exp_error;
    int          exp_loads;
    logic [63:0] exp_log;   // issued codes, first issued in the high nibble
    int          exp_done;
    logic [3:0]  exp_fs;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int idx);
    vec_t v;
    int l0, s0, d0, qb;
    logic [63:0] obs;
    v = vecs[idx];
    l0 = loads; s0 = stores; d0 = dones; qb = ld_q.size();
    fin_abs = (v.fin_at > 0) ? l0 + v.fin_at : 0;
    init_state = {30{4'(idx + 1)}};
    push_moves(v.n, v.codes);
    pulse_start();
    wait_end($sformatf("v%0d end", idx), 400);
    repeat (4) @(negedge clk);
    obs = '0;
    for (int k = qb; k < ld_q.size(); k++) obs = {obs[59:0], ld_q[k]};
    chk($sformatf("v%0d move_cnt", idx), move_cnt, v.exp_cnt);
    chk($sformatf("v%0d solved", idx), solved, v.exp_solved);
    chk($sformatf("v%0d error", idx), error, v.exp_error);
    chk($sformatf("v%0d loads", idx), loads - l0, v.exp_loads);
    chk($sformatf("v%0d load_codes", idx), obs, v.exp_log);
    chk($sformatf("v%0d done_pulses", idx), dones - d0, v.exp_done);
    chk($sformatf("v%0d stores", idx), stores - s0, 1);
    chk($sformatf("v%0d store_data", idx), cb_store_data, {30{4'(idx + 1)}});
    chk($sformatf("v%0d mv_empty", idx), mv_empty, 1'b1);
    chk($sformatf("v%0d busy", idx), busy, 1'b0);
    if (v.exp_cnt > 0)
      chk($sformatf("v%0d final_state", idx), final_state, {30{v.exp_fs}});
  endtask

  initial begin
    int l0, s0, n_ld;
    bit seen;
    //        n  codes          fin cnt sol err lds log          done fs
    vecs[0] = '{2, 64'h73,       0, 2, 0, 0, 2, 64'h37,       1, 4'h7};
    vecs[1] = '{5, 64'hA8642,    2, 2, 1, 0, 2, 64'h24,       1, 4'h4};
    vecs[2] = '{2, 64'hE1,       0, 1, 0, 1, 1, 64'h1,        0, 4'h1};
    vecs[3] = '{0, 64'h0,        0, 0, 0, 0, 0, 64'h0,        1, 4'h0};
    vecs[4] = '{1, 64'hC,        0, 0, 0, 1, 0, 64'h0,        0, 4'h0};
    vecs[5] = '{3, 64'h5B0,      1, 1, 1, 0, 1, 64'h0,        1, 4'h0};
    vecs[6] = '{3, 64'h90B,      0, 3, 0, 0, 3, 64'hB09,      1, 4'h9};

    repeat (3) @(negedge clk);
    chk("reset outputs",
        {busy, done, solved, error, overflow, cb_store, cb_load, mv_full, mv_empty},
        9'b000000001);
    chk("reset move_cnt", move_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Timeout: error exactly TMO cycles after WAIT entry.
    cube_dead = 1'b1;
    fin_abs = 0;
    push_moves(1, 64'h4);
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cb_load === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tmo load seen", seen, 1'b1);
    repeat (TMO_T - 1) @(negedge clk);
    chk("tmo error early", error, 1'b0);
    @(negedge clk);
    chk("tmo error at TMO", error, 1'b1);
    chk("tmo busy", busy, 1'b0);
    cube_dead = 1'b0;
    repeat (2) @(negedge clk);

    // ERR ignores a start held through entry; needs a low cycle first.
    s0 = stores;
    push_moves(1, 64'hD);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("errhold run started", busy, 1'b1);
    wait_end("errhold end", 50);
    repeat (3) @(negedge clk);
    chk("errhold held error", error, 1'b1);
    chk("errhold ignores start", busy, 1'b0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("errhold restart busy", busy, 1'b1);
    chk("errhold restart error clear", error, 1'b0);
    wait_end("errhold restart end", 50);
    chk("errhold stores", stores - s0, 2);
    repeat (2) @(negedge clk);

    // Overflow: DEPTH+1 pushes, exactly DEPTH moves executed, start mid-run ignored.
    l0 = loads; s0 = stores;
    for (int i = 0; i <= DEPTH_T; i++) begin
      @(negedge clk);
      mv_wr = 1'b1;
      mv_data = 4'(i % 12);
    end
    @(negedge clk);
    mv_wr = 1'b0;
    chk("ovf mv_full", mv_full, 1'b1);
    chk("ovf overflow", overflow, 1'b1);
    pulse_start();
    chk("ovf cleared by start", overflow, 1'b0);
    repeat (10) @(negedge clk);
    pulse_start();
    wait_end("ovf end", 600);
    repeat (3) @(negedge clk);
    chk("ovf move_cnt", move_cnt, DEPTH_T);
    chk("ovf loads", loads - l0, DEPTH_T);
    chk("ovf stores", stores - s0, 1);
    chk("ovf final_state", final_state, {30{4'h3}});
    chk("ovf mv_empty", mv_empty, 1'b1);

    // Reset during WAIT of the second move.
    push_moves(2, 64'h65);
    pulse_start();
    n_ld = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (cb_load === 1'b1) n_ld++;
      if (n_ld == 2) break;
    end
    chk("rst reached 2nd load", n_ld, 2);
    rst_n = 1'b0;
    #1;
    chk("rst flags",
        {busy, done, solved, error, overflow, cb_store, cb_load, mv_full, mv_empty},
        9'b000000001);
    chk("rst move_cnt", move_cnt, 0);
    chk("rst final_state", final_state, 120'h0);
    chk("rst store_data", cb_store_data, 120'h0);
    chk("rst cb_d", cb_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    l0 = loads; s0 = stores;
    repeat (20) @(negedge clk);
    chk("rst no loads after", loads - l0, 0);
    chk("rst no stores after", stores - s0, 0);

    chk("pulse rules", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cube_sequencer.md
CUBE_SEQUENCER -- requirements
Module: cube_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning move-queue entries (power of two, >=2).
REQ-002 SHALL have parameter TMO, default 15, meaning max cycles to wait for cb_valid per move.
REQ-003 SHALL have port clk, input, 1, meaning clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning begin a run; sampled only in IDLE.
REQ-006 SHALL have port init_state, input, 120, meaning cube state loaded at run start.
REQ-007 SHALL have port mv_wr, input, 1, meaning push mv_data into the move queue.
REQ-008 SHALL have port mv_data, input, 4, meaning move code; 0-11 are legal, 12-15 are illegal.
REQ-009 SHALL have port mv_full / mv_empty, output, 1 each, meaning queue full / empty flags.
REQ-010 SHALL have port cb_store, output, 1, meaning one-cycle store pulse to the cube core.
REQ-011 SHALL have port cb_store_data, output, 120, meaning the registered copy of init_state.
REQ-012 SHALL have port cb_load, output, 1, meaning one-cycle move-issue pulse to the cube core.
REQ-013 SHALL have port cb_d, output, 4, meaning the move code presented with cb_load.
REQ-014 SHALL have ports cb_valid, cb_fin (input, 1 each) and cb_q (input, 120), meaning move complete, cube solved, resulting state.
REQ-015 SHALL have ports busy, done, solved, error, overflow (output, 1 each); move_cnt (output, 8); final_state (output, 120).

Function
REQ-016 Queue SHALL be a DEPTH-entry FIFO: push on mv_wr when not full; pop only by the FSM.
REQ-017 Push while full SHALL be dropped and set overflow (sticky until next start); push and pop in the same cycle while full SHALL both succeed.
REQ-018 FSM states SHALL be IDLE, STORE, SETTLE, ISSUE, WAIT, DONE, ERR.
REQ-019 IDLE: start=1 SHALL register init_state, clear move_cnt/solved/error/overflow/done, and go to STORE next cycle.
REQ-020 STORE: cb_store=1 for exactly one cycle with cb_store_data valid, then go to SETTLE.
REQ-021 SETTLE: one idle cycle (cb_store=0, cb_load=0), then go to ISSUE.
REQ-022 ISSUE with an empty queue SHALL go to DONE with solved=0.
REQ-023 ISSUE with a head entry of 12-15 SHALL pop it, set error=1, and go to ERR without asserting cb_load.
REQ-024 ISSUE with a legal head entry SHALL pop it, drive cb_d=code and cb_load=1 for one cycle, clear the timeout counter, and go to WAIT.
REQ-025 WAIT: cb_valid=1 SHALL capture cb_q into final_state and increment move_cnt, saturating at 255.
REQ-026 In that same WAIT cycle, cb_fin=1 SHALL set solved=1, flush the queue (mv_empty=1 next cycle), and go to DONE; otherwise the FSM SHALL go to ISSUE.
REQ-027 WAIT: if TMO cycles elapse without cb_valid, the FSM SHALL set error=1 and go to ERR.
REQ-028 DONE: done=1 for one cycle, then go to IDLE; solved, move_cnt and final_state SHALL hold until the next start.
REQ-029 ERR: the FSM SHALL hold and ignore start until start is seen after one full cycle with start=0, then behave as IDLE+start.
REQ-030 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-031 start outside IDLE/ERR SHALL be ignored.
REQ-032 mv_wr SHALL be accepted in every state.
REQ-033 cb_store/cb_load SHALL never be asserted together, and neither SHALL be asserted in consecutive cycles.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE; queue empty (mv_empty=1, mv_full=0); all 1-bit outputs 0 except mv_empty; move_cnt=0; final_state=0; cb_store_data=0; cb_d=0.
REQ-035 Reset mid-run SHALL abandon the run with no further cube pulses.

Verification
REQ-036 Push moves 3,7 then start, with cube returning cb_valid 2 cycles after each cb_load and cb_fin=0 -> one cb_store, cb_load with cb_d=3 then 7, done pulse, move_cnt=2, solved=0.
REQ-037 Push 5 moves, cb_fin=1 on the 2nd move -> solved=1, move_cnt=2, queue empty, only 2 cb_load pulses.
REQ-038 Push 1,14 then start -> one cb_load (d=1), then error=1, state ERR, no second cb_load.
REQ-039 Push one move, cube never asserts cb_valid -> error=1 exactly TMO cycles after WAIT entry.
REQ-040 Push DEPTH+1 moves while idle -> mv_full=1 and overflow=1; start then executes exactly DEPTH moves.
REQ-041 Assert rst_n=0 during WAIT -> all outputs at reset values the same cycle; the bench SHALL check no cb_load is issued after release.
